// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDU_valid,
    input  logic [3:0]  E_MDUop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDUout
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
    localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic          start, is_mul, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic [63:0]   prod;

    assign start  = E_MDU_valid && state_q == IDLE && E_MDUop >= OP_MULT && E_MDUop <= OP_DIVU;
    assign is_mul = op_q == OP_MULT || op_q == OP_MULTU;
    assign prod   = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q}
                                      : {32'b0, a_q} * {32'b0, b_q};
    // Signed divide works on magnitudes, which also yields 0x80000000/-1 -> LO=0x80000000, HI=0
    assign a_neg  = op_q == OP_DIV && a_q[31];
    assign b_neg  = op_q == OP_DIV && b_q[31];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_neg ? -b_q : b_q;
    assign q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == RUN) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                if (is_mul) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q != 32'd0) begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (start) begin
            state_d = RUN;
            op_d    = E_MDUop;
            a_d     = E_A;
            b_d     = E_B;
            cnt_d   = (E_MDUop <= OP_MULTU) ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end else if (E_MDU_valid) begin
            hi_d = (E_MDUop == OP_MTHI) ? E_A : hi_q;
            lo_d = (E_MDUop == OP_MTLO) ? E_A : lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign E_MDU_busy = state_q == RUN;
    assign E_MDUout   = (E_MDUop == OP_MFHI) ? hi_q : (E_MDUop == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; expected reads and busy-run lengths are queued by stimulus
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic        E_MDU_valid;
    logic [3:0]  E_MDUop;
    logic [31:0] E_A, E_B;
    logic        E_MDU_busy;
    logic [31:0] E_MDUout;

    typedef struct {
        string       n;
        logic [31:0] v;
    } exp_t;

    exp_t rd_q[$];
    int   busy_q[$];
    int   tests = 0;
    int   fails = 0;
    int   run   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDU_valid(E_MDU_valid), .E_MDUop(E_MDUop),
        .E_A(E_A), .E_B(E_B), .E_MDU_busy(E_MDU_busy), .E_MDUout(E_MDUout)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDU_valid = 1'b1;
        E_MDUop     = op;
        E_A         = a;
        E_B         = b;
        step();
        E_MDU_valid = 1'b0;
        E_MDUop     = 4'd0;
    endtask

    task automatic rd(input string n, input logic [3:0] op, input logic [31:0] exp);
        rd_q.push_back('{n: n, v: exp});
        issue(op, 32'd0, 32'd0);
    endtask

    task automatic wait_idle(input string n);
        for (int i = 0; i < 40 && E_MDU_busy; i++) step();
        if (E_MDU_busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still 1 after 40 cycles, expected 0", n);
        end
    endtask

    // Monitor: measures each busy run and compares presented mfhi/mflo values
    always @(negedge clk) begin
        if (E_MDU_busy) begin
            run++;
        end else if (run > 0) begin
            if (busy_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL busy_run: got unexpected run of %0d cycles, expected none", run);
            end else begin
                check("busy_len", 32'(run), 32'(busy_q.pop_front()));
            end
            run = 0;
        end
        if (E_MDU_valid && (E_MDUop == 4'd5 || E_MDUop == 4'd6)) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL read: got unexpected read %h, expected no read", E_MDUout);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                check(e.n, E_MDUout, e.v);
            end
        end
    end

    initial begin
        reset       = 1'b0;
        E_MDU_valid = 1'b1;
        E_MDUop     = 4'd1;
        E_A         = 32'h0000_0007;
        E_B         = 32'h0000_0003;
        step();
        E_MDUop = 4'd7;
        step();
        check("rst_busy", {31'd0, E_MDU_busy}, 32'd0);
        reset       = 1'b1;
        E_MDU_valid = 1'b0;
        E_MDUop     = 4'd0;
        rd("rst_hi", 4'd5, 32'd0);
        rd("rst_lo", 4'd6, 32'd0);

        busy_q.push_back(5);
        issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("mult");
        rd("mult_hi", 4'd5, 32'hFFFF_FFFF);
        rd("mult_lo", 4'd6, 32'hFFFF_FFFE);

        busy_q.push_back(5);
        issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("multu");
        rd("multu_hi", 4'd5, 32'h0000_0001);
        rd("multu_lo", 4'd6, 32'hFFFF_FFFE);

        busy_q.push_back(10);
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
        rd("inflight_hi", 4'd5, 32'h0000_0001);
        wait_idle("div");
        rd("div_lo", 4'd6, 32'hFFFF_FFFD);
        rd("div_hi", 4'd5, 32'hFFFF_FFFF);

        busy_q.push_back(10);
        issue(4'd4, 32'h0000_0007, 32'h0000_0000);
        wait_idle("divu0");
        rd("divz_lo", 4'd6, 32'hFFFF_FFFD);
        rd("divz_hi", 4'd5, 32'hFFFF_FFFF);

        busy_q.push_back(10);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");
        rd("ovf_lo", 4'd6, 32'h8000_0000);
        rd("ovf_hi", 4'd5, 32'h0000_0000);

        busy_q.push_back(5);
        issue(4'd1, 32'h0001_0000, 32'h0003_0005);
        issue(4'd7, 32'h0000_1234, 32'd0);
        wait_idle("mthi_busy");
        issue(4'd8, 32'h0000_ABCD, 32'd0);
        rd("mtlo_lo", 4'd6, 32'h0000_ABCD);
        rd("mthi_ign", 4'd5, 32'h0000_0003);
        issue(4'd7, 32'h0000_0055, 32'd0);
        rd("mthi_hi", 4'd5, 32'h0000_0055);

        busy_q.push_back(5);
        busy_q.push_back(10);
        issue(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle("b2b_mult");
        issue(4'd3, 32'd100, 32'd7);
        wait_idle("b2b_div");
        rd("b2b_lo", 4'd6, 32'd14);
        rd("b2b_hi", 4'd5, 32'd2);

        busy_q.push_back(5);
        busy_q.push_back(3);
        issue(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_idle("abort_mult");
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_busy", {31'd0, E_MDU_busy}, 32'd0);
        rd("abort_hi", 4'd5, 32'd0);
        rd("abort_lo", 4'd6, 32'd0);

        step();
        step();
        tests++;
        if (rd_q.size() != 0 || busy_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d reads and %0d busy runs pending, expected 0 and 0",
                     rd_q.size(), busy_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit with architectural HI/LO registers. It runs mult, multu, div and divu over a fixed number of cycles and reports busy for that whole period. It also executes mthi/mtlo writes and supplies the mfhi/mflo read value. It produces E_MDUout, which the E/M pipeline register consumes, and E_MDU_busy, which the hazard unit uses to stall MDU instructions in D.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (≥1)
- clk  input  1  clock; all state changes on posedge
- reset  input  1  synchronous, active-low: state clears on a posedge where reset==0
- E_MDU_valid  input  1  E holds a live MDU instruction this cycle (bubbles drive 0)
- E_MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- E_MDU_busy  output  1  operation in progress
- E_MDUout  output  32  HI when op==5, LO when op==6, else 0 (combinational from HI/LO)

## Operation
- State: HI[31:0], LO[31:0], busy flag, counter cnt[3:0] (widen to cover max(MULT_CYCLES, DIV_CYCLES)), latched op, latched operands.
- FSM IDLE/RUN: IDLE→RUN on a posedge with E_MDU_valid && op∈{1..4} && !busy. Latch op, E_A, E_B; load cnt with N−1 (N = MULT_CYCLES or DIV_CYCLES).
- In RUN, cnt decrements each cycle. On the posedge where cnt==0: commit HI/LO, go to IDLE.
- mult: {HI,LO} = signed(A)×signed(B), 64-bit. multu: unsigned 64-bit product.
- div: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned quotient/remainder.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero, div or divu: full DIV_CYCLES busy period still runs; HI/LO keep their prior values at commit.
- mthi / mtlo: with valid && !busy, HI←E_A or LO←E_A at the posedge. Single cycle; never sets busy.
- Any op with valid while busy is ignored: no start, no HI/LO write. The hazard unit guarantees this never occurs; the behaviour is defined only for robustness.
- mfhi/mflo never modify state. E_MDUout reflects committed HI/LO only; in-flight results are invisible until commit.

## Timing
- Reset (posedge with reset==0): HI=0, LO=0, busy=0, cnt=0, FSM=IDLE.
  - E_MDU_busy=0 and E_MDUout=0 from the next cycle.
  - Reset mid-operation aborts it; no commit.
- Start accepted at posedge t:
  - E_MDU_busy=1 for cycles t+1 … t+N.
  - HI/LO updated at posedge t+N, at which point busy falls.
  - New HI/LO are visible on E_MDUout from cycle t+N+1.
- A new start in the cycle right after busy falls is accepted (back-to-back, no gap cycle).
- mthi/mtlo at posedge t: the new value is readable by mfhi/mflo in cycle t+1.
- Busy is registered, not combinational from E_MDUop. The hazard unit additionally stalls on a start op present in E; the MDU has no obligation there.
- N=1 is legal: busy high for exactly one cycle.

## Test plan
- Reset: hold reset=0 two cycles with valid ops applied -> busy=0; mfhi/mflo read 0.
- mult A=0xFFFFFFFF, B=0x00000002 -> busy exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/0 -> busy 10 cycles; HI/LO unchanged.
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi 0x1234 while busy -> ignored; HI becomes the mult result at commit.
  - mtlo 0xABCD in the cycle after commit -> mflo reads 0xABCD next cycle.
- Back-to-back starts: mult then div in the first idle cycle -> busy continuous except the single cycle at the commit boundary, total 5+10 busy cycles.
  - Reset=0 at cycle 3 of the div -> busy 0; HI/LO = 0.
